fft_bitrev_buf: RTL and testbench
=================================

FFT_BITREV_BUF -- requirements
Module: fft_bitrev_buf

Interface
REQ-001 Parameter DATA_W, default 48: sample width, {re[23:0], im[23:0]}; treated as opaque bits.
REQ-002 Parameter LOG2N, default 7: log2 of frame length; N = 128.
REQ-003 i_clk  input  1  single clock, rising-edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_data  input  DATA_W  upstream sample, natural order.
REQ-006 i_data_valid  input  1  upstream sample valid.
REQ-007 o_data_ready  output  1  block can accept i_data this cycle.
REQ-008 o_data  output  DATA_W  reordered sample.
REQ-009 o_data_valid  output  1  o_data holds a valid sample.
REQ-010 i_data_ready  input  1  downstream accepts o_data.
REQ-011 o_rd_index  output  LOG2N  read position (0..N-1) of the sample on o_data.

Function
REQ-012 Storage: two banks, each N x DATA_W (ping-pong); per-bank full flag; write pointer wr_bank and wr_idx; read pointer rd_bank and rd_idx.
REQ-013 Input transfer: occurs on a rising edge with i_data_valid=1 and o_data_ready=1; the sample is written to bank wr_bank at address wr_idx, and wr_idx increments modulo N.
REQ-014 o_data_ready = NOT full[wr_bank]; combinational from registers only, with no path from i_data_valid.
REQ-015 A transfer at wr_idx=N-1 sets full[wr_bank], toggles wr_bank, and wraps wr_idx to 0 on the same edge.
REQ-016 Output register load condition: (o_data_valid=0 OR i_data_ready=1) AND full[rd_bank]=1.
REQ-017 On load: o_data <= bank[rd_bank][bitrev(rd_idx)], where bitrev reverses the LOG2N bits; o_rd_index <= rd_idx; o_data_valid <= 1; rd_idx increments modulo N.
REQ-018 A load at rd_idx=N-1 clears full[rd_bank] and toggles rd_bank on the same edge.
REQ-019 If o_data_valid=1, i_data_ready=1, and the load condition is false, o_data_valid <= 0 and o_data holds its value.
REQ-020 If o_data_valid=1 and i_data_ready=0, o_data, o_rd_index and o_data_valid hold.
REQ-021 Latency: when the last sample of a frame is accepted at edge E with the output idle, the first reordered sample (input position 0) is valid after edge E+1.
REQ-022 Throughput: with i_data_valid=1 and i_data_ready=1 held continuously, input and output each sustain 1 sample/cycle with no bubbles after the first frame.
REQ-023 Simultaneous events: setting full[wr_bank] and clearing full[rd_bank] on the same edge are independent; the writer never targets a full bank.
REQ-024 Both banks full: o_data_ready=0 until the reader clears full[rd_bank]. o_data_ready rises the cycle after that clear.
REQ-025 Partial frame: no output is produced until all N samples are written.

Reset
REQ-026 While i_rst_n=0, the following are asynchronously forced to zero: wr_idx, rd_idx, wr_bank, rd_bank, both full flags, o_data, o_rd_index and o_data_valid.
REQ-027 o_data_ready=1 during and after reset.
REQ-028 Bank memory contents are not reset.
REQ-029 Reset mid-frame discards all buffered and partial frames; the next accepted sample is position 0 of bank 0.

Configuration
REQ-030 Macro FFT_BITREV_LAST_EN, when defined: adds output o_data_last (1 bit). It is registered with o_data, equals 1 when the loaded rd_idx = N-1, holds under back-pressure, and resets to 0.
REQ-031 Without FFT_BITREV_LAST_EN: the o_data_last port and its logic are absent; all other behaviour is identical.

Verification
REQ-032 Order check.
- Stimulus: reset release, i_data_valid=1, i_data_ready=1, i_data = 1..128.
- Required: o_data sequence 1, 65, 33, 97, 17, 81, ...; sample 128 appears last; o_rd_index counts 0..127.
REQ-033 Continuous stream.
- Stimulus: i_data incrementing from 1 for 4 frames (512 samples), both valids/readies held at 1.
- Required: o_data_ready never drops; o_data_valid continuous from the cycle after sample 128 is accepted; frame k output equals bitrev order offset by 128k.
REQ-034 Full back-pressure.
- Stimulus: i_data_ready=0, 300 samples offered.
- Required: exactly 256 accepted; o_data_ready=0 from the cycle after the 256th acceptance; o_data holds value 1.
- Then: raise i_data_ready; o_data_ready returns to 1 one cycle after the 128th output.
REQ-035 Random stalls.
- Stimulus: randomized i_data_valid and i_data_ready, each at 50%, over 10 frames.
- Required: output matches the reference bitrev model; no duplicated or dropped sample; o_data is stable while o_data_valid=1 and i_data_ready=0.
REQ-036 Reset mid-operation.
- Stimulus: assert i_rst_n=0 after 70 samples of frame 2.
- Required: all outputs are 0 and o_data_ready=1 immediately; the next frame 1..128 reproduces the REQ-032 order.
REQ-037 Last flag, with FFT_BITREV_LAST_EN defined.
- Required: o_data_last=1 only with o_data=128 in frame 1.
- Without the macro, the bench compiles with no o_data_last connection.

Source files
------------

// File: rtl/fft_bitrev_buf.sv
// fft_bitrev_buf: ping-pong frame buffer that emits each N-sample frame in bit-reversed order
// Ports: i_clk / i_rst_n (async active-low) clock and reset;
//   i_data, i_data_valid, o_data_ready   upstream natural-order sample stream;
//   o_data, o_data_valid, i_data_ready   downstream reordered sample stream;
//   o_rd_index                           read position of the sample on o_data;
//   o_data_last                          final sample of a frame, present only with FFT_BITREV_LAST_EN.
module fft_bitrev_buf #(
  parameter int DATA_W = 48,
  parameter int LOG2N  = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic [LOG2N-1:0]  o_rd_index
`ifdef FFT_BITREV_LAST_EN
  ,
  output logic              o_data_last
`endif
);
  localparam int N = 1 << LOG2N;
  logic [DATA_W-1:0] mem_q [2*N];
  logic [LOG2N-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rd_rev, index_q, index_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, valid_q, valid_d;
  logic [1:0] full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic wr_en, ld, wr_last, rd_last;
  for (genvar b = 0; b < LOG2N; b++) begin : g_rev
    assign rd_rev[b] = rd_idx_q[LOG2N-1-b];
  end
  // Ready depends on registered state only, so upstream valid never loops back into it.
  assign o_data_ready = ~full_q[wr_bank_q];
  assign wr_en = i_data_valid & o_data_ready;
  assign ld = (~valid_q | i_data_ready) & full_q[rd_bank_q];
  assign wr_last = wr_en & (&wr_idx_q);
  assign rd_last = ld & (&rd_idx_q);
  // The writer only ever fills an empty bank and the reader only drains a full one,
  // so the set and clear below can never hit the same flag on one edge.
  always_comb begin
    wr_idx_d = wr_en ? wr_idx_q + LOG2N'(1) : wr_idx_q;
    rd_idx_d = ld ? rd_idx_q + LOG2N'(1) : rd_idx_q;
    wr_bank_d = wr_bank_q ^ wr_last;
    rd_bank_d = rd_bank_q ^ rd_last;
    full_d = full_q;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
    data_d = ld ? mem_q[{rd_bank_q, rd_rev}] : data_q;
    index_d = ld ? rd_idx_q : index_q;
    valid_d = ld | (valid_q & ~i_data_ready);
  end
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[{wr_bank_q, wr_idx_q}] <= i_data;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q <= '0;
      data_q <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q <= full_d;
      data_q <= data_d;
      index_q <= index_d;
      valid_q <= valid_d;
    end
  end
  assign o_data = data_q;
  assign o_data_valid = valid_q;
  assign o_rd_index = index_q;
`ifdef FFT_BITREV_LAST_EN
  logic last_q, last_d;
  assign last_d = ld ? (&rd_idx_q) : last_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) last_q <= 1'b0;
    else last_q <= last_d;
  end
  assign o_data_last = last_q;
`endif
endmodule

// File: tb/tb_fft_bitrev_buf.sv
// tb_fft_bitrev_buf: directed checks of the bit-reversing ping-pong buffer
module tb_fft_bitrev_buf;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [47:0] data = '0;
  logic dv = 1'b0;
  logic dr = 1'b0;
  logic rdy, ovalid;
  logic [47:0] odata;
  logic [6:0] oidx;
`ifdef FFT_BITREV_LAST_EN
  logic olast;
`endif
  int vectors = 0;
  int miscompares = 0;
  int in_cnt = 0;
  int out_cnt = 0;
  fft_bitrev_buf #(.DATA_W(48), .LOG2N(7)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_data(data),
    .i_data_valid(dv),
    .o_data_ready(rdy),
    .o_data(odata),
    .o_data_valid(ovalid),
    .i_data_ready(dr),
    .o_rd_index(oidx)
`ifdef FFT_BITREV_LAST_EN
    ,
    .o_data_last(olast)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] rev(input logic [6:0] x);
    for (int i = 0; i < 7; i++) rev[i] = x[6-i];
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    dv = 1'b0;
    dr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_now", {rdy, ovalid, oidx, odata}, {1'b1, 1'b0, 7'd0, 48'd0});
`ifdef FFT_BITREV_LAST_EN
    chk("rst_last", olast, 1'b0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold", {rdy, ovalid, oidx, odata}, {1'b1, 1'b0, 7'd0, 48'd0});
    rst_n = 1'b1;
    in_cnt = 0;
    out_cnt = 0;
    data = 48'd1;
  endtask
  // One clock: score any output handshake, advance, then check back-pressure hold.
  task automatic tick();
    logic acc, take, hold;
    logic [47:0] hv;
    logic [6:0] hi, ei;
    acc = dv && rdy;
    take = ovalid && dr;
    hold = ovalid && !dr;
    hv = odata;
    hi = oidx;
    if (take) begin
      ei = 7'(out_cnt % 128);
      chk("order", odata, 64'((out_cnt / 128) * 128 + int'(rev(ei)) + 1));
      chk("index", oidx, ei);
`ifdef FFT_BITREV_LAST_EN
      chk("last", olast, (ei == 7'd127) ? 1'b1 : 1'b0);
`endif
      out_cnt++;
    end
    @(posedge clk);
    #1;
    if (acc) in_cnt++;
    data = 48'(in_cnt + 1);
    if (hold) chk("hold", {ovalid, oidx, odata}, {1'b1, hi, hv});
  endtask
  initial begin
    do_reset();
    dr = 1'b1;
    for (int t = 0; t <= 650; t++) begin
      chk("valid_stream", ovalid, (t >= 129 && t <= 640) ? 1'b1 : 1'b0);
      if (t < 512) chk("ready_stream", rdy, 1'b1);
      dv = (in_cnt < 512);
      tick();
    end
    chk("stream_count", out_cnt, 512);
    do_reset();
    for (int t = 0; t < 300; t++) begin
      dv = 1'b1;
      chk("ready_bp", rdy, (t < 256) ? 1'b1 : 1'b0);
      tick();
    end
    chk("bp_accepted", in_cnt, 256);
    chk("bp_data", {ovalid, odata}, {1'b1, 48'd1});
    dv = 1'b0;
    dr = 1'b1;
    for (int u = 0; u < 300; u++) begin
      if (u <= 128) chk("ready_drain", rdy, (u >= 127) ? 1'b1 : 1'b0);
      tick();
    end
    chk("bp_count", out_cnt, 256);
    do_reset();
    for (int t = 0; t < 20000 && out_cnt < 1280; t++) begin
      dv = (in_cnt < 1280) && ($urandom_range(0, 1) == 1);
      dr = ($urandom_range(0, 1) == 1);
      tick();
    end
    chk("rand_in", in_cnt, 1280);
    chk("rand_out", out_cnt, 1280);
    do_reset();
    dv = 1'b1;
    dr = 1'b1;
    for (int t = 0; t < 1000 && in_cnt < 198; t++) tick();
    chk("mid_in", in_cnt, 198);
    do_reset();
    dr = 1'b1;
    for (int t = 0; t < 1000 && out_cnt < 128; t++) begin
      dv = (in_cnt < 128);
      tick();
    end
    chk("after_rst_out", out_cnt, 128);
    chk("after_rst_in", in_cnt, 128);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
